// File: rtl/shift_ctrl.sv
// shift_ctrl: multi-pass sequencer in front of an 8-bit combinational
// barrel shifter (at most 7 positions per pass). It turns a 0-31 shift
// amount into a sequence of passes, feeding each pass result back
// through the shifter.
// Optional feature: define SHIFT_ROT_EN to build rotate-right (op 11)
// from two shifter passes. Without it, op 11 is answered immediately
// with res_err=1 and the operand unchanged.
module shift_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic [4:0] cmd_amt,
  input  logic [1:0] cmd_op,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic       busy,
  output logic [7:0] sh_din,
  output logic [2:0] sh_shamt,
  output logic       sh_lr,
  output logic       sh_al,
  input  logic [7:0] sh_dout
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
`ifdef SHIFT_ROT_EN
    ROT_R = 3'd2,
    ROT_L = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] work;
  logic [4:0] rem;
  logic [1:0] op;
  logic [2:0] step;
  logic [4:0] rem_next;
`ifdef SHIFT_ROT_EN
  logic [7:0] part;
  logic [3:0] rot_left4;
`endif

  // Per-pass shift size: never more than the shifter can do, never more than what is left.
  always_comb begin
    step     = (rem > 5'd7) ? 3'd7 : rem[2:0];
    rem_next = rem - {2'b00, step};
  end

`ifdef SHIFT_ROT_EN
  // Left half of a rotate shifts by 8-k; k is 1..7 here, so the 3-bit result never wraps.
  always_comb begin
    rot_left4 = 4'd8 - {1'b0, rem[2:0]};
  end
`endif

  // Commands are only taken in IDLE, and never while reset is held.
  always_comb begin
    cmd_ready = rst_n && (state == IDLE);
  end

  // Shifter drive per state; IDLE and DONE park it at a zero shift of the working value.
  always_comb begin
    sh_din   = work;
    sh_shamt = 3'd0;
    sh_lr    = 1'b0;
    sh_al    = 1'b0;
    case (state)
      RUN: begin
        sh_shamt = step;
        sh_lr    = (op == OP_SLL);
        sh_al    = (op == OP_SRA);
      end
`ifdef SHIFT_ROT_EN
      ROT_R: sh_shamt = rem[2:0];
      ROT_L: begin
        sh_shamt = rot_left4[2:0];
        sh_lr    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer: accept, run the passes, then hold the registered result until it is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= 8'h00;
      rem       <= 5'd0;
      op        <= 2'b00;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      busy      <= 1'b0;
`ifdef SHIFT_ROT_EN
      part      <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            work    <= cmd_data;
            rem     <= cmd_amt;
            op      <= cmd_op;
            res_err <= 1'b0;
            busy    <= 1'b1;
            if (cmd_op == OP_ROR) begin
`ifdef SHIFT_ROT_EN
              if (cmd_amt[2:0] != 3'd0) begin
                state <= ROT_R;
              end else begin
                state     <= DONE;
                res_valid <= 1'b1;
                res_data  <= cmd_data;
              end
`else
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= cmd_data;
              res_err   <= 1'b1;
`endif
            end else if (cmd_amt != 5'd0) begin
              state <= RUN;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= cmd_data;
            end
          end
        end
        RUN: begin
          work <= sh_dout;
          rem  <= rem_next;
          if (rem_next == 5'd0) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= sh_dout;
          end
        end
`ifdef SHIFT_ROT_EN
        ROT_R: begin
          part  <= sh_dout;
          state <= ROT_L;
        end
        ROT_L: begin
          work      <= part | sh_dout;
          res_data  <= part | sh_dout;
          res_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed-vector bench for shift_ctrl with a behavioural
// barrel shifter attached to the sh_* port. Expected values are worked out
// by hand in the vector table. Honours SHIFT_ROT_EN for the rotate rows.
module tb_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [4:0] cmd_amt;
  logic [1:0] cmd_op;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic       busy;
  logic [7:0] sh_din;
  logic [2:0] sh_shamt;
  logic       sh_lr;
  logic       sh_al;
  logic [7:0] sh_dout;

  int checks = 0;
  int errors = 0;

  logic [2:0] pass_amt [0:7];
  logic       pass_lr  [0:7];
  int         pass_cnt;

  typedef struct {
    logic [7:0] d;
    logic [4:0] a;
    logic [1:0] o;
    logic [7:0] exp_d;
    logic       exp_e;
    int         exp_lat;
    int         exp_np;
    logic [2:0] exp_first;
    logic       exp_first_lr;
    logic [2:0] exp_last;
  } vec_t;

  vec_t vecs [$];

  shift_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_amt   (cmd_amt),
    .cmd_op    (cmd_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy),
    .sh_din    (sh_din),
    .sh_shamt  (sh_shamt),
    .sh_lr     (sh_lr),
    .sh_al     (sh_al),
    .sh_dout   (sh_dout)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream barrel shifter.
  always_comb begin
    if (sh_lr)
      sh_dout = sh_din << sh_shamt;
    else if (sh_al)
      sh_dout = 8'($signed(sh_din) >>> sh_shamt);
    else
      sh_dout = sh_din >> sh_shamt;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command and wait (bounded) until its result is presented; the result is left unconsumed.
  task automatic applyStimulus(input logic [7:0] d, input logic [4:0] a, input logic [1:0] o,
                               output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_amt   = a;
    cmd_op    = o;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pass_cnt = 0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (res_valid) lat = i;
      else if (sh_shamt != 3'd0 && pass_cnt < 8) begin
        pass_amt[pass_cnt] = sh_shamt;
        pass_lr[pass_cnt]  = sh_lr;
        pass_cnt++;
      end
    end
    if (lat == 0) checkOutput("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic consumeResult();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    logic stale;
    logic [7:0] held;

    vecs.push_back('{8'h81, 5'd1,  2'b00, 8'h02, 1'b0, 2, 1, 3'd1, 1'b1, 3'd1});
    vecs.push_back('{8'h90, 5'd20, 2'b10, 8'hFF, 1'b0, 4, 3, 3'd7, 1'b0, 3'd6});
    vecs.push_back('{8'h90, 5'd20, 2'b01, 8'h00, 1'b0, 4, 3, 3'd7, 1'b0, 3'd6});
    vecs.push_back('{8'hF0, 5'd0,  2'b01, 8'hF0, 1'b0, 1, 0, 3'd0, 1'b0, 3'd0});
    vecs.push_back('{8'h01, 5'd31, 2'b00, 8'h00, 1'b0, 6, 5, 3'd7, 1'b1, 3'd3});
    vecs.push_back('{8'h40, 5'd6,  2'b10, 8'h01, 1'b0, 2, 1, 3'd6, 1'b0, 3'd6});
    vecs.push_back('{8'hB4, 5'd3,  2'b01, 8'h16, 1'b0, 2, 1, 3'd3, 1'b0, 3'd3});
    vecs.push_back('{8'h0F, 5'd9,  2'b00, 8'h00, 1'b0, 3, 2, 3'd7, 1'b1, 3'd2});
    vecs.push_back('{8'h7F, 5'd7,  2'b10, 8'h00, 1'b0, 2, 1, 3'd7, 1'b0, 3'd7});
`ifdef SHIFT_ROT_EN
    vecs.push_back('{8'h12, 5'd12, 2'b11, 8'h21, 1'b0, 3, 2, 3'd4, 1'b0, 3'd4});
    vecs.push_back('{8'h81, 5'd1,  2'b11, 8'hC0, 1'b0, 3, 2, 3'd1, 1'b0, 3'd7});
    vecs.push_back('{8'h12, 5'd8,  2'b11, 8'h12, 1'b0, 1, 0, 3'd0, 1'b0, 3'd0});
`else
    vecs.push_back('{8'h12, 5'd12, 2'b11, 8'h12, 1'b1, 1, 0, 3'd0, 1'b0, 3'd0});
    vecs.push_back('{8'h81, 5'd1,  2'b11, 8'h81, 1'b1, 1, 0, 3'd0, 1'b0, 3'd0});
    vecs.push_back('{8'h12, 5'd8,  2'b11, 8'h12, 1'b1, 1, 0, 3'd0, 1'b0, 3'd0});
`endif

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_amt   = 5'd0;
    cmd_op    = 2'b00;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data",  32'(res_data),  32'h00);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_res_err",   32'(res_err),   32'd0);
    rst_n = 1'b1;
    #1 checkOutput("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].d, vecs[i].a, vecs[i].o, lat);
      checkOutput($sformatf("v%0d_data", i), 32'(res_data), 32'(vecs[i].exp_d));
      checkOutput($sformatf("v%0d_err", i),  32'(res_err),  32'(vecs[i].exp_e));
      checkOutput($sformatf("v%0d_lat", i),  32'(lat),      32'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_npass", i), 32'(pass_cnt), 32'(vecs[i].exp_np));
      if (vecs[i].exp_np > 0 && pass_cnt > 0) begin
        checkOutput($sformatf("v%0d_first_amt", i), 32'(pass_amt[0]), 32'(vecs[i].exp_first));
        checkOutput($sformatf("v%0d_first_lr", i),  32'(pass_lr[0]),  32'(vecs[i].exp_first_lr));
        checkOutput($sformatf("v%0d_last_amt", i),  32'(pass_amt[pass_cnt-1]), 32'(vecs[i].exp_last));
      end
      consumeResult();
    end

    // Backpressure: result must hold while res_ready stays low.
    applyStimulus(8'hF0, 5'd0, 2'b01, lat);
    held = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_data", i),  32'(res_data),  32'(held));
      checkOutput($sformatf("bp%0d_valid", i), 32'(res_valid), 32'd1);
      checkOutput($sformatf("bp%0d_ready", i), 32'(cmd_ready), 32'd0);
      checkOutput($sformatf("bp%0d_busy", i),  32'(busy),      32'd1);
    end
    consumeResult();
    checkOutput("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);
    checkOutput("bp_valid_after",     32'(res_valid), 32'd0);

    // res_ready and cmd_valid together in DONE: the new command waits one cycle.
    applyStimulus(8'h03, 5'd5, 2'b00, lat);
    checkOutput("sim_first_data", 32'(res_data), 32'h60);
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 8'h55;
    cmd_amt   = 5'd0;
    cmd_op    = 2'b01;
    @(posedge clk);
    #1 res_ready = 1'b0;
    checkOutput("sim_idle_busy",  32'(busy),      32'd0);
    checkOutput("sim_idle_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checkOutput("sim_accept_busy", 32'(busy),      32'd1);
    checkOutput("sim_accept_valid", 32'(res_valid), 32'd1);
    checkOutput("sim_accept_data", 32'(res_data),  32'h55);
    consumeResult();

    // Reset in the middle of a long SRA: the command must vanish without a result.
    cmd_valid = 1'b1;
    cmd_data  = 8'h80;
    cmd_amt   = 5'd31;
    cmd_op    = 2'b10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_valid", 32'(res_valid), 32'd0);
    checkOutput("mid_rst_busy",  32'(busy),      32'd0);
    checkOutput("mid_rst_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1 checkOutput("mid_rel_ready", 32'(cmd_ready), 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid || busy) stale = 1'b1;
    end
    checkOutput("mid_no_stale", 32'(stale), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
